pll_lock_detect: RTL and testbench

//  Frequency lock detector for the TX PLL. Consumes the feedback clock from the PLL clock divider.

---
 rtl/pll_pkg.sv | 19 +
 rtl/pll_edge_sync.sv | 38 +++
 rtl/pll_lock_detect.sv | 202 ++++++++++++++++++++
 tb/tb_pll_lock_detect.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// ----------------------------------------------------------------------------
// pll_pkg
// Shared definitions for the TX PLL frequency lock detector.
//   pll_state_t       : measurement FSM state encoding
//   DEFAULT_LOCK_WIN  : default count of consecutive good windows needed for lock
// ----------------------------------------------------------------------------
package pll_pkg;

    // IDLE waits for enable, MEASURE counts feedback edges over the window,
    // EVAL is the single cycle in which a finished window's result is visible.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_EVAL    = 2'd2
    } pll_state_t;

    localparam int DEFAULT_LOCK_WIN = 4;

endpackage

// File: rtl/pll_edge_sync.sv
// ----------------------------------------------------------------------------
// pll_edge_sync
// Brings an asynchronous clock-like signal into the Ref_Clk domain and turns
// each of its rising edges into a single Ref_Clk-wide pulse.
// Ports:
//   Ref_Clk  in   reference clock
//   rst      in   asynchronous active-low reset
//   d_async  in   asynchronous input (divided PLL feedback clock)
//   rise     out  one-cycle pulse per synchronized rising edge of d_async
// ----------------------------------------------------------------------------
module pll_edge_sync (
    input  logic Ref_Clk,
    input  logic rst,
    input  logic d_async,
    output logic rise
);

    logic sync_1;
    logic sync_2;
    logic sync_3;

    // Two flops resolve metastability; the third holds the previous
    // synchronized value so an edge can be detected.
    always_ff @(posedge Ref_Clk or negedge rst) begin
        if (!rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            sync_3 <= 1'b0;
        end else begin
            sync_1 <= d_async;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
        end
    end

    assign rise = sync_2 & ~sync_3;

endmodule

// File: rtl/pll_lock_detect.sv
// ----------------------------------------------------------------------------
// pll_lock_detect
// Frequency lock detector for the TX PLL. Counts rising edges of the divided
// feedback clock over a programmable window of Ref_Clk cycles, compares the
// count against an expected value within a tolerance and declares lock after
// LOCK_WIN consecutive good windows. The first bad window drops lock.
// Parameters:
//   WIN_W     width of the window length
//   CNT_W     width of edge counter, expected count and tolerance
//   LOCK_WIN  consecutive good windows needed for lock (>= 1)
// Ports:
//   Ref_Clk     in   reference clock, sole clock of the block
//   rst         in   asynchronous active-low reset
//   enable      in   1 runs measurements, 0 returns to idle and clears lock
//   fb_clk      in   divided feedback clock, asynchronous, < Ref_Clk/3
//   win_len     in   window length in Ref_Clk cycles (0 behaves as 1)
//   exp_cnt     in   expected feedback edges per window
//   tol         in   allowed |measured - expected|
//   fb_count    out  edge count of the last completed window
//   meas_valid  out  one-cycle pulse when fb_count has been updated
//   locked      out  lock status
//   lock_lost   out  one-cycle pulse when a bad window drops lock
// ----------------------------------------------------------------------------
module pll_lock_detect
    import pll_pkg::*;
#(
    parameter int WIN_W    = 10,
    parameter int CNT_W    = 8,
    parameter int LOCK_WIN = DEFAULT_LOCK_WIN
) (
    input  logic             Ref_Clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fb_clk,
    input  logic [WIN_W-1:0] win_len,
    input  logic [CNT_W-1:0] exp_cnt,
    input  logic [CNT_W-1:0] tol,
    output logic [CNT_W-1:0] fb_count,
    output logic             meas_valid,
    output logic             locked,
    output logic             lock_lost
);

    localparam int GOOD_W = $clog2(LOCK_WIN + 1);

    pll_state_t       state;
    pll_state_t       state_next;

    logic             fb_rise;

    logic [WIN_W-1:0] win_len_q;
    logic [CNT_W-1:0] exp_q;
    logic [CNT_W-1:0] tol_q;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] edge_cnt;

    logic [WIN_W-1:0] win_len_eff;
    logic [CNT_W-1:0] edge_cnt_inc;
    logic             start_window;
    logic             window_done;
    logic [CNT_W:0]   abs_diff;
    logic             good;
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] good_cnt_next;

    pll_edge_sync u_edge_sync (
        .Ref_Clk (Ref_Clk),
        .rst     (rst),
        .d_async (fb_clk),
        .rise    (fb_rise)
    );

    // Window bookkeeping. The edge count including the current cycle is used
    // both for accumulation and for the final result, so the last window
    // cycle's edge is never lost. A new window starts either when leaving
    // IDLE or in the EVAL cycle, and that cycle's edge belongs to it.
    always_comb begin
        win_len_eff  = (win_len == '0) ? WIN_W'(1) : win_len;
        edge_cnt_inc = edge_cnt;
        if (fb_rise && (edge_cnt != {CNT_W{1'b1}})) begin
            edge_cnt_inc = edge_cnt + CNT_W'(1);
        end
        start_window = enable && ((state == ST_IDLE) || (state == ST_EVAL));
        window_done  = enable && (state == ST_MEASURE) && (win_cnt == win_len_q);
    end

    // Distance from the expected count, one bit wider than the operands so
    // neither direction of the subtraction can wrap.
    always_comb begin
        if (edge_cnt_inc >= exp_q) begin
            abs_diff = {1'b0, edge_cnt_inc} - {1'b0, exp_q};
        end else begin
            abs_diff = {1'b0, exp_q} - {1'b0, edge_cnt_inc};
        end
        good = (abs_diff <= {1'b0, tol_q});
    end

    // Good-window streak, held at LOCK_WIN once reached.
    always_comb begin
        good_cnt_next = good_cnt;
        if (good_cnt != GOOD_W'(LOCK_WIN)) begin
            good_cnt_next = good_cnt + GOOD_W'(1);
        end
    end

    // Next-state logic; dropping enable always wins and aborts any window.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (window_done) begin
                    state_next = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_MEASURE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Ref_Clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Window and edge counters. Configuration is captured only at window
    // start so mid-window changes cannot corrupt the measurement in flight.
    always_ff @(posedge Ref_Clk or negedge rst) begin
        if (!rst) begin
            win_len_q <= '0;
            exp_q     <= '0;
            tol_q     <= '0;
            win_cnt   <= '0;
            edge_cnt  <= '0;
        end else if (!enable) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
        end else if (start_window) begin
            win_len_q <= win_len_eff;
            exp_q     <= exp_cnt;
            tol_q     <= tol;
            win_cnt   <= WIN_W'(1);
            edge_cnt  <= CNT_W'(fb_rise);
        end else if (state == ST_MEASURE) begin
            win_cnt  <= win_cnt + WIN_W'(1);
            edge_cnt <= edge_cnt_inc;
        end
    end

    // Result and lock tracking. Everything is registered on the last window
    // cycle so meas_valid, fb_count, locked and lock_lost change together in
    // the EVAL cycle. Disabling clears lock silently, without lock_lost.
    always_ff @(posedge Ref_Clk or negedge rst) begin
        if (!rst) begin
            fb_count   <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            lock_lost  <= 1'b0;
            good_cnt   <= '0;
        end else begin
            meas_valid <= window_done;
            lock_lost  <= 1'b0;
            if (!enable) begin
                locked   <= 1'b0;
                good_cnt <= '0;
            end else if (window_done) begin
                fb_count <= edge_cnt_inc;
                if (good) begin
                    good_cnt <= good_cnt_next;
                    if (good_cnt_next == GOOD_W'(LOCK_WIN)) begin
                        locked <= 1'b1;
                    end
                end else begin
                    good_cnt <= '0;
                    if (locked) begin
                        locked    <= 1'b0;
                        lock_lost <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_detect.sv
// ----------------------------------------------------------------------------
// tb_pll_lock_detect
// Directed bench for pll_lock_detect. Feedback edges are produced as bursts of
// pulses started at each window boundary, so every window sees a known edge
// count. Expected window results go into a scoreboard when a window's
// stimulus is launched and are compared when meas_valid appears.
// A window spans win_len+1 sampled Ref_Clk cycles (the EVAL cycle plus
// win_len measuring cycles), so lengths are chosen to hold whole bursts.
// ----------------------------------------------------------------------------
module tb_pll_lock_detect;

    localparam int LOCK_WIN = 4;

    logic       Ref_Clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       fb_clk = 1'b0;
    logic [9:0] win_len;
    logic [7:0] exp_cnt;
    logic [7:0] tol;
    logic [7:0] fb_count;
    logic       meas_valid;
    logic       locked;
    logic       lock_lost;

    typedef struct {
        int count;
        bit locked;
        bit lost;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    int gen_half  = 2;
    int burst_n   = 0;
    int burst_seq = 0;
    int seen_seq  = 0;
    int left      = 0;
    int phase     = 0;

    int m_exp    = 0;
    int m_tol    = 0;
    int m_good   = 0;
    bit m_locked = 1'b0;
    int cur_len  = 1;

    bit prev_valid = 1'b0;

    pll_lock_detect #(
        .WIN_W    (10),
        .CNT_W    (8),
        .LOCK_WIN (LOCK_WIN)
    ) dut (
        .Ref_Clk    (Ref_Clk),
        .rst        (rst),
        .enable     (enable),
        .fb_clk     (fb_clk),
        .win_len    (win_len),
        .exp_cnt    (exp_cnt),
        .tol        (tol),
        .fb_count   (fb_count),
        .meas_valid (meas_valid),
        .locked     (locked),
        .lock_lost  (lock_lost)
    );

    always #5 Ref_Clk = ~Ref_Clk;

    // Feedback pulse generator: a new burst request restarts the pattern of
    // burst_n pulses, each gen_half cycles high then gen_half cycles low.
    always @(posedge Ref_Clk) begin
        #2;
        if (burst_seq != seen_seq) begin
            seen_seq = burst_seq;
            left     = burst_n;
            phase    = 0;
        end
        if (left > 0) begin
            fb_clk = (phase < gen_half);
            phase++;
            if (phase == 2 * gen_half) begin
                phase = 0;
                left--;
            end
        end else begin
            fb_clk = 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Scoreboard consumer: every meas_valid pops one expected window result;
    // meas_valid and lock_lost must both be single-cycle pulses.
    always @(negedge Ref_Clk) begin
        if (rst) begin
            if (prev_valid) begin
                checkOutput("meas_valid width", meas_valid, 0);
                checkOutput("lock_lost width", lock_lost, 0);
            end
            if (meas_valid) begin
                if (sb_q.size() == 0) begin
                    checkOutput("scoreboard depth", sb_q.size(), 1);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    checkOutput("fb_count", fb_count, e.count);
                    checkOutput("locked", locked, e.locked);
                    checkOutput("lock_lost", lock_lost, e.lost);
                end
            end
            prev_valid = meas_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // Lock model: saturating count, good/bad window against tolerance.
    task automatic pushExpected(input int edges);
        exp_t e;
        int   c;
        int   d;
        bit   good;
        c = (edges > 255) ? 255 : edges;
        d = (c >= m_exp) ? c - m_exp : m_exp - c;
        good = (d <= m_tol);
        e.lost = 1'b0;
        if (good) begin
            if (m_good < LOCK_WIN) m_good++;
            if (m_good == LOCK_WIN) m_locked = 1'b1;
        end else begin
            m_good   = 0;
            e.lost   = m_locked;
            m_locked = 1'b0;
        end
        e.count  = c;
        e.locked = m_locked;
        sb_q.push_back(e);
    endtask

    task automatic waitValid(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge Ref_Clk);
            n++;
        end while (!meas_valid && n < cur_len + 10);
        checkOutput({tag, " period"}, n, cur_len + 1);
    endtask

    task automatic launchBurst(input int n, input int half);
        gen_half = half;
        burst_n  = n;
        burst_seq++;
    endtask

    task automatic startRun(input int len, input int e, input int t,
                            input int n, input int half);
        @(negedge Ref_Clk);
        win_len = 10'(len);
        exp_cnt = 8'(e);
        tol     = 8'(t);
        m_exp   = e;
        m_tol   = t;
        cur_len = (len == 0) ? 1 : len;
        launchBurst(n, half);
        enable = 1'b1;
        pushExpected(n);
        waitValid("start");
    endtask

    task automatic applyStimulus(input int n, input int half);
        launchBurst(n, half);
        pushExpected(n);
        waitValid("window");
    endtask

    task automatic stopRun(input string tag);
        @(negedge Ref_Clk);
        enable   = 1'b0;
        m_good   = 0;
        m_locked = 1'b0;
        @(negedge Ref_Clk);
        checkOutput({tag, " locked"}, locked, 0);
        checkOutput({tag, " lock_lost"}, lock_lost, 0);
        repeat (2) @(negedge Ref_Clk);
    endtask

    initial begin : main
        int seen;

        rst     = 1'b0;
        enable  = 1'b0;
        win_len = '0;
        exp_cnt = '0;
        tol     = '0;
        repeat (3) @(negedge Ref_Clk);
        checkOutput("reset fb_count", fb_count, 0);
        checkOutput("reset meas_valid", meas_valid, 0);
        checkOutput("reset locked", locked, 0);
        checkOutput("reset lock_lost", lock_lost, 0);
        rst = 1'b1;
        repeat (2) @(negedge Ref_Clk);

        $display("[TB] period-4 feedback, exact count, lock on 4th window");
        startRun(15, 4, 0, 4, 2);
        repeat (3) applyStimulus(4, 2);
        checkOutput("lock after 4 good", locked, 1);

        $display("[TB] feedback slows to period 8, lock drops");
        applyStimulus(2, 4);
        stopRun("stop after loss");

        $display("[TB] counts 3/5 within tol 1");
        startRun(23, 4, 1, 3, 2);
        applyStimulus(5, 2);
        applyStimulus(3, 2);
        applyStimulus(5, 2);
        checkOutput("lock with tol 1", locked, 1);

        $display("[TB] enable dropped mid-window while locked");
        repeat (5) @(negedge Ref_Clk);
        enable   = 1'b0;
        m_good   = 0;
        m_locked = 1'b0;
        @(negedge Ref_Clk);
        checkOutput("abort locked", locked, 0);
        checkOutput("abort lock_lost", lock_lost, 0);
        seen = 0;
        repeat (cur_len + 5) begin
            @(negedge Ref_Clk);
            if (meas_valid) seen++;
        end
        checkOutput("abort meas_valid count", seen, 0);
        checkOutput("abort fb_count hold", fb_count, 5);

        $display("[TB] counts 3/5 with tol 0 never lock");
        startRun(23, 4, 0, 3, 2);
        applyStimulus(5, 2);
        applyStimulus(3, 2);
        applyStimulus(5, 2);
        applyStimulus(3, 2);
        stopRun("stop tol 0");

        $display("[TB] feedback idle, expected 0");
        startRun(15, 0, 0, 0, 2);
        repeat (3) applyStimulus(0, 2);
        checkOutput("idle fb lock", locked, 1);
        stopRun("stop idle");

        $display("[TB] win_len 0 behaves as 1");
        startRun(0, 0, 0, 0, 2);
        repeat (3) applyStimulus(0, 2);
        stopRun("stop len 0");

        $display("[TB] saturation at 255 with 256 edges");
        startRun(1023, 255, 0, 0, 2);
        repeat (4) applyStimulus(256, 2);
        checkOutput("saturated lock", locked, 1);

        repeat (100) @(negedge Ref_Clk);
        #2;
        rst    = 1'b0;
        enable = 1'b0;
        #1;
        checkOutput("async rst fb_count", fb_count, 0);
        checkOutput("async rst meas_valid", meas_valid, 0);
        checkOutput("async rst locked", locked, 0);
        checkOutput("async rst lock_lost", lock_lost, 0);
        m_good   = 0;
        m_locked = 1'b0;
        repeat (3) @(negedge Ref_Clk);
        rst = 1'b1;
        repeat (5) @(negedge Ref_Clk);
        checkOutput("scoreboard drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
